// File: rtl/rapids_boot_ctrl.sv
// Boot sequencer for a rapids core: streams program/register words into memory and
// register-file write ports, runs the core, and reports status. Optional: RAPIDS_BOOT_CHECKSUM_EN.
module rapids_boot_ctrl #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 10,
    parameter int REG_ADDR_W = 5,
    parameter int CYC_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [CYC_W-1:0]      timeout_limit,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_W-1:0]     in_data,
    input  logic                  in_sel,
    input  logic                  in_last,
    output logic                  mem_we,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    output logic                  reg_we,
    output logic [REG_ADDR_W-1:0] reg_addr,
    output logic [DATA_W-1:0]     reg_wdata,
    output logic                  go,
    input  logic                  halt,
    output logic                  busy,
    output logic                  done,
    output logic                  timeout,
    output logic                  load_ovf,
    output logic [CYC_W-1:0]      cycles,
    output logic [DATA_W-1:0]     checksum
);

    typedef enum logic [2:0] {IDLE, LOAD, RUN, DONE, FAIL} state_t;

    state_t                  state, state_nxt;
    logic [ADDR_W-1:0]       mem_ptr;
    logic [REG_ADDR_W-1:0]   reg_ptr;
    logic                    hs;
    logic                    start_ok;
    logic [CYC_W-1:0]        cyc_inc;
    logic                    timeout_hit;

    assign hs          = in_valid & in_ready;
    assign start_ok    = start & ((state == IDLE) | (state == DONE) | (state == FAIL));
    assign cyc_inc     = cycles + 1'b1;
    // cyc_inc is the count this RUN cycle will have completed; limit 0 disables the check
    assign timeout_hit = (timeout_limit != '0) && (cyc_inc == timeout_limit);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE, FAIL: if (start) state_nxt = LOAD;
            LOAD:             if (hs && in_last) state_nxt = RUN;
            RUN: begin
                if (halt)             state_nxt = DONE;
                else if (timeout_hit) state_nxt = FAIL;
            end
            default:          state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready = (state == LOAD);
        go       = (state == RUN);
        busy     = (state == LOAD) || (state == RUN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            reg_we    <= 1'b0;
            reg_addr  <= '0;
            reg_wdata <= '0;
            mem_ptr   <= '0;
            reg_ptr   <= '0;
            done      <= 1'b0;
            timeout   <= 1'b0;
            load_ovf  <= 1'b0;
            cycles    <= '0;
        end else begin
            mem_we <= 1'b0;
            reg_we <= 1'b0;
            if (start_ok) begin
                mem_ptr  <= '0;
                reg_ptr  <= '0;
                cycles   <= '0;
                done     <= 1'b0;
                timeout  <= 1'b0;
                load_ovf <= 1'b0;
            end
            if (hs) begin
                if (!in_sel) begin
                    mem_we    <= 1'b1;
                    mem_addr  <= mem_ptr;
                    mem_wdata <= in_data;
                    mem_ptr   <= mem_ptr + 1'b1;
                    if (&mem_ptr) load_ovf <= 1'b1;
                end else begin
                    reg_we    <= 1'b1;
                    reg_addr  <= reg_ptr;
                    reg_wdata <= in_data;
                    reg_ptr   <= reg_ptr + 1'b1;
                    if (&reg_ptr) load_ovf <= 1'b1;
                end
            end
            if (state == RUN) begin
                if (!(&cycles)) cycles <= cyc_inc;
                if (halt)             done    <= 1'b1;
                else if (timeout_hit) timeout <= 1'b1;
            end
        end
    end

`ifdef RAPIDS_BOOT_CHECKSUM_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        checksum <= '0;
        else if (start_ok) checksum <= '0;
        else if (hs)       checksum <= checksum + in_data;
    end
`else
    assign checksum = '0;
`endif

endmodule

// File: tb/tb_rapids_boot_ctrl.sv
// Self-checking bench for rapids_boot_ctrl: directed and randomized load/run sessions
// checked against a transaction-level model of pointers, status and run length.
module tb_rapids_boot_ctrl;

    localparam int DW = 32;
    localparam int AW = 2;
    localparam int RW = 2;
    localparam int CW = 8;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk, rst_n, start, in_valid, in_ready, in_sel, in_last;
    logic [CW-1:0] timeout_limit;
    logic [DW-1:0] in_data, mem_wdata, reg_wdata, checksum;
    logic [AW-1:0] mem_addr;
    logic [RW-1:0] reg_addr;
    logic          mem_we, reg_we, go, halt, busy, done, timeout, load_ovf;
    logic [CW-1:0] cycles;

    rapids_boot_ctrl #(.DATA_W(DW), .ADDR_W(AW), .REG_ADDR_W(RW), .CYC_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .timeout_limit(timeout_limit),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_sel(in_sel),
        .in_last(in_last), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .reg_we(reg_we), .reg_addr(reg_addr), .reg_wdata(reg_wdata), .go(go), .halt(halt),
        .busy(busy), .done(done), .timeout(timeout), .load_ovf(load_ovf), .cycles(cycles),
        .checksum(checksum)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // reference model state
    int            m_mptr, m_rptr, m_cyc;
    bit            m_ovf, m_done, m_to;
    logic [DW-1:0] m_sum;
    logic [DW-1:0] words_q[$];
    bit            sels_q[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] exp_sum();
`ifdef RAPIDS_BOOT_CHECKSUM_EN
        return m_sum;
`else
        return '0;
`endif
    endfunction

    function automatic int min_i(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    task automatic chk_status(input string where);
        chk({where, ".done"},     done,     m_done);
        chk({where, ".timeout"},  timeout,  m_to);
        chk({where, ".load_ovf"}, load_ovf, m_ovf);
        chk({where, ".cycles"},   cycles,   m_cyc);
        chk({where, ".checksum"}, checksum, exp_sum());
    endtask

    task automatic model_clear();
        m_mptr = 0; m_rptr = 0; m_cyc = 0;
        m_ovf = 0; m_done = 0; m_to = 0; m_sum = '0;
    endtask

    // Start a session and stream words_q/sels_q with random valid gaps; returns in RUN cycle 1.
    task automatic load_session(input int limit);
        int  n, idx, guard, ea;
        bit  v, s;
        n = words_q.size();
        @(negedge clk);
        timeout_limit = CW'(limit);
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        model_clear();
        chk("load_entry.in_ready", in_ready, 1);
        chk("load_entry.busy", busy, 1);
        chk("load_entry.go", go, 0);
        chk_status("load_entry");
        idx = 0;
        guard = 0;
        while (idx < n && guard < 1000) begin
            v        = ($urandom_range(0, 3) != 0);
            s        = v ? sels_q[idx] : 1'($urandom_range(0, 1));
            in_valid = v;
            in_sel   = s;
            in_data  = v ? words_q[idx] : DW'($urandom);
            in_last  = v ? (idx == n - 1) : 1'($urandom_range(0, 1));
            halt     = 1'($urandom_range(0, 1));
            start    = 1'($urandom_range(0, 1));
            @(posedge clk);
            @(negedge clk);
            chk("load.mem_we", mem_we, v && !s);
            chk("load.reg_we", reg_we, v && s);
            if (v) begin
                m_sum = m_sum + words_q[idx];
                if (!s) begin
                    ea = m_mptr;
                    if (m_mptr == (1 << AW) - 1) m_ovf = 1;
                    m_mptr = (m_mptr + 1) % (1 << AW);
                    chk("load.mem_addr", mem_addr, ea);
                    chk("load.mem_wdata", mem_wdata, words_q[idx]);
                end else begin
                    ea = m_rptr;
                    if (m_rptr == (1 << RW) - 1) m_ovf = 1;
                    m_rptr = (m_rptr + 1) % (1 << RW);
                    chk("load.reg_addr", reg_addr, ea);
                    chk("load.reg_wdata", reg_wdata, words_q[idx]);
                end
                idx++;
            end
            chk("load.go", go, idx == n);
            chk("load.in_ready", in_ready, idx != n);
            chk("load.busy", busy, 1);
            chk_status("load");
            guard++;
        end
        if (idx < n) chk("load.budget", 0, 1);
        in_valid = 1'b0; in_last = 1'b0; in_sel = 1'b0; start = 1'b0; halt = 1'b0;
    endtask

    // Run from RUN cycle 1; halt raised during RUN cycle halt_at (0 = never).
    task automatic run_session(input int halt_at, input int limit);
        int k, cb;
        bit ended;
        k = 1;
        ended = 0;
        while (!ended && k <= 400) begin
            halt = (k == halt_at);
            @(posedge clk);
            @(negedge clk);
            halt = 1'b0;
            cb = min_i(k - 1, CMAX);
            m_cyc = min_i(k, CMAX);
            if (k == halt_at) begin
                m_done = 1; ended = 1;
            end else if (limit != 0 && ((cb + 1) % (1 << CW)) == limit) begin
                m_to = 1; ended = 1;
            end
            if (ended || k % 16 == 0) begin
                chk("run.go", go, !ended);
                chk("run.busy", busy, !ended);
                chk_status("run");
            end
            k++;
        end
        if (!ended) chk("run.budget", 0, 1);
        // halt and start-free idle cycles afterwards must leave status untouched
        repeat (2) begin
            halt = 1'b1;
            @(posedge clk);
            @(negedge clk);
            chk("post.go", go, 0);
            chk("post.in_ready", in_ready, 0);
            chk("post.mem_we", mem_we | reg_we, 0);
            chk_status("post");
        end
        halt = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; timeout_limit = '0; in_valid = 1'b0; in_data = '0;
        in_sel = 1'b0; in_last = 1'b0; halt = 1'b0;
        model_clear();
        #12;
        chk("reset.go", go, 0);
        chk("reset.busy", busy, 0);
        chk("reset.in_ready", in_ready, 0);
        chk("reset.strobes", {mem_we, reg_we}, 0);
        chk_status("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // directed program load, then halt
        words_q = '{32'h9E010004, 32'h9E020006, 32'h80801020};
        sels_q  = '{1'b0, 1'b0, 1'b0};
        load_session(0);
        run_session(3, 0);

        // register word first, halt in 5th RUN cycle
        words_q = '{32'h00000010, 32'h12345678, 32'hCAFEF00D};
        sels_q  = '{1'b1, 1'b0, 1'b0};
        load_session(0);
        run_session(5, 0);

        // timeout after 8 cycles, no halt
        words_q = '{32'hA5A5A5A5};
        sels_q  = '{1'b0};
        load_session(8);
        run_session(0, 8);

        // halt and timeout together: halt wins
        load_session(4);
        run_session(4, 4);

        // memory pointer wrap
        words_q = '{32'h1, 32'h2, 32'h3, 32'h4, 32'h5};
        sels_q  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        load_session(0);
        run_session(2, 0);

        // register pointer wrap
        sels_q  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        load_session(0);
        run_session(1, 0);

        // cycle counter saturation with timeout disabled
        words_q = '{32'hDEADBEEF};
        sels_q  = '{1'b1};
        load_session(0);
        run_session(300, 0);

        // randomized sessions
        for (int s = 0; s < 8; s++) begin
            int n, lim, h;
            words_q = {};
            sels_q  = {};
            n = $urandom_range(1, 7);
            for (int i = 0; i < n; i++) begin
                words_q.push_back(DW'($urandom));
                sels_q.push_back(1'($urandom_range(0, 1)));
            end
            lim = $urandom_range(0, 12);
            h   = $urandom_range(1, 15);
            load_session(lim);
            run_session(h, lim);
        end

        // asynchronous reset mid-RUN
        words_q = '{32'h0BADF00D, 32'h00000077};
        sels_q  = '{1'b0, 1'b1};
        load_session(0);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        model_clear();
        chk("midrun_rst.go", go, 0);
        chk("midrun_rst.busy", busy, 0);
        chk("midrun_rst.strobes", {mem_we, reg_we}, 0);
        chk("midrun_rst.mem_addr", mem_addr, 0);
        chk_status("midrun_rst");
        @(negedge clk);
        rst_n = 1'b1;
        words_q = '{32'h11111111, 32'h22222222};
        sels_q  = '{1'b0, 1'b0};
        load_session(0);
        run_session(2, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
